// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding and
// truth-table constants for common two-input gates and the inverter.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } gate_seq_state_e;

    // Bit i is the expected gate output for input vector i.
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [1:0] TT_NOT   = 2'b01;

endpackage

// File: rtl/led_dimmer.sv
// LED dimmer: free-running counter that gates a steady LED request down to a
// DIM_ON / 2^DIM_BITS duty cycle.
module led_dimmer #(
    parameter int unsigned DIM_BITS = 8,
    parameter int unsigned DIM_ON   = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic in,
    output logic out
);

    localparam logic [DIM_BITS:0] DimOnThr = (DIM_BITS + 1)'(DIM_ON);

    logic [DIM_BITS-1:0] r_dim_cnt;
    logic                w_dim_lit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dim_cnt <= '0;
        end else begin
            r_dim_cnt <= r_dim_cnt + DIM_BITS'(1);
        end
    end

    // One extra bit so DIM_ON == 2^DIM_BITS means fully on.
    assign w_dim_lit = ({1'b0, r_dim_cnt} < DimOnThr);
    assign out       = in & w_dim_lit;

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive self-test controller for one combinational gate under test.
// Define GATE_SEQ_DIM_EN to dim the pass/fail LEDs through led_dimmer.
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned N_INPUTS      = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] EXPECT        = 16'h0007,
    parameter int unsigned DIM_BITS      = 8,
    parameter int unsigned DIM_ON        = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    output logic [N_INPUTS-1:0] dut_a,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] fail_vec,
    output logic                LED_PASS,
    output logic                LED_FAIL
);

    localparam int unsigned NumVec  = 2 ** N_INPUTS;
    localparam int unsigned CntW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [N_INPUTS:0] VecLast = (N_INPUTS + 1)'(NumVec - 1);

    if (N_INPUTS < 1 || N_INPUTS > 4) begin : g_bad_n_inputs
        $error("gate_test_sequencer: N_INPUTS must be 1..4");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_test_sequencer: SETTLE_CYCLES must be >= 1");
    end
    if (DIM_BITS < 1 || DIM_ON > 2 ** DIM_BITS) begin : g_bad_dim
        $error("gate_test_sequencer: DIM_ON must not exceed 2^DIM_BITS");
    end

    gate_seq_state_e     r_state;
    gate_seq_state_e     w_state_next;

    logic                r_start_meta;
    logic                r_start_sync;
    logic                r_start_prev;
    logic                w_start_pulse;

    logic [N_INPUTS:0]   r_vec;
    logic [CntW-1:0]     r_settle_cnt;
    logic [N_INPUTS:0]   r_err_count;
    logic [N_INPUTS-1:0] r_fail_vec;
    logic                r_first_fail;
    logic [N_INPUTS-1:0] r_dut_a;

    logic [NumVec-1:0]   w_tt;
    logic                w_mismatch;
    logic                w_last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_start_meta <= START;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
        end
    end

    assign w_start_pulse = r_start_sync & ~r_start_prev;

    assign w_tt       = EXPECT[NumVec-1:0];
    assign w_mismatch = (dut_y != w_tt[r_vec[N_INPUTS-1:0]]);
    assign w_last     = (r_vec == VecLast);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE: if (w_start_pulse) w_state_next = DRIVE;
            DRIVE:      w_state_next = SETTLE;
            SETTLE:     if (r_settle_cnt == '0) w_state_next = SAMPLE;
            SAMPLE:     w_state_next = w_last ? DONE : DRIVE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            DRIVE, SETTLE, SAMPLE: busy = 1'b1;
            DONE:                  done = 1'b1;
            default:               ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_fail_vec   <= '0;
            r_first_fail <= 1'b0;
            r_dut_a      <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_start_pulse) begin
                        r_vec        <= '0;
                        r_err_count  <= '0;
                        r_fail_vec   <= '0;
                        r_first_fail <= 1'b0;
                    end
                end
                DRIVE: begin
                    r_dut_a      <= r_vec[N_INPUTS-1:0];
                    r_settle_cnt <= CntW'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - CntW'(1);
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + (N_INPUTS + 1)'(1);
                        if (!r_first_fail) begin
                            r_fail_vec   <= r_vec[N_INPUTS-1:0];
                            r_first_fail <= 1'b1;
                        end
                    end
                    // Park the GUT inputs at 0 once the sweep completes.
                    if (w_last) r_dut_a <= '0;
                    else        r_vec   <= r_vec + (N_INPUTS + 1)'(1);
                end
                default: ;
            endcase
        end
    end

    assign dut_a     = r_dut_a;
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;
    assign pass      = done & (r_err_count == '0);

`ifdef GATE_SEQ_DIM_EN
    led_dimmer #(
        .DIM_BITS (DIM_BITS),
        .DIM_ON   (DIM_ON)
    ) u_dim_pass (
        .CLK   (CLK),
        .RST_N (RST_N),
        .in    (pass),
        .out   (LED_PASS)
    );

    led_dimmer #(
        .DIM_BITS (DIM_BITS),
        .DIM_ON   (DIM_ON)
    ) u_dim_fail (
        .CLK   (CLK),
        .RST_N (RST_N),
        .in    (done & ~pass),
        .out   (LED_FAIL)
    );
`else
    assign LED_PASS = pass;
    assign LED_FAIL = done & ~pass;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench for gate_test_sequencer: directed and randomised GUT truth
// tables checked against a vector-sweep reference model.
module tb_gate_test_sequencer;
    import gate_seq_pkg::*;

    localparam int unsigned N      = 2;
    localparam int unsigned S      = 4;
    localparam int unsigned NV     = 4;
    localparam int unsigned RunLen = NV * (S + 2);
`ifdef GATE_SEQ_DIM_EN
    localparam int DutyOn = 8;
`else
    localparam int DutyOn = 256;
`endif

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         START;
    logic [3:0]   gut_n;
    logic [3:0]   gut_a;

    logic [N-1:0] dut_a_n, dut_a_a;
    logic         dut_y_n, dut_y_a;
    logic         busy_n, busy_a, done_n, done_a, pass_n, pass_a;
    logic [N:0]   err_n, err_a;
    logic [N-1:0] fail_n, fail_a;
    logic         led_pass_n, led_fail_n, led_pass_a, led_fail_a;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    // Behavioural GUTs: truth table indexed by the applied vector.
    assign dut_y_n = gut_n[dut_a_n];
    assign dut_y_a = gut_a[dut_a_a];

    gate_test_sequencer #(
        .N_INPUTS      (N),
        .SETTLE_CYCLES (S),
        .EXPECT        ({12'h000, TT_NAND2})
    ) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .dut_a     (dut_a_n),
        .dut_y     (dut_y_n),
        .busy      (busy_n),
        .done      (done_n),
        .pass      (pass_n),
        .err_count (err_n),
        .fail_vec  (fail_n),
        .LED_PASS  (led_pass_n),
        .LED_FAIL  (led_fail_n)
    );

    gate_test_sequencer #(
        .N_INPUTS      (N),
        .SETTLE_CYCLES (S),
        .EXPECT        ({12'h000, TT_AND2})
    ) u_dut_and (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .dut_a     (dut_a_a),
        .dut_y     (dut_y_a),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .err_count (err_a),
        .fail_vec  (fail_a),
        .LED_PASS  (led_pass_a),
        .LED_FAIL  (led_fail_a)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Sweep every vector; count mismatches and remember the first one.
    function automatic void ref_run(input logic [3:0] gut, input logic [3:0] tt,
                                    output int errs, output int first);
        errs  = 0;
        first = 0;
        for (int v = 0; v < NV; v++) begin
            if (gut[v] !== tt[v]) begin
                if (errs == 0) first = v;
                errs++;
            end
        end
    endfunction

    // mode 0: short START pulse; 1: START held through DONE; 2: extra pulse mid-run.
    task automatic run(input string tag, input logic [3:0] gn, input logic [3:0] ga,
                       input int mode);
        int cyc, k, e_n, f_n, e_a, f_a;
        int lp_n, lf_n, lp_a, lf_a, dn;
        @(negedge CLK);
        gut_n = gn;
        gut_a = ga;
        START = 1'b1;
        cyc   = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!busy_n && cyc < 20);
        check({tag, ":start_lat"}, 32'(cyc), 32'd3);
        k = 0;
        while (!done_n && k < 200) begin
            check({tag, ":dut_a"}, 32'(dut_a_n), (k == 0) ? 32'd0 : 32'((k - 1) / (S + 2)));
            if (mode != 1 && k == 2) START = 1'b0;
            if (mode == 2 && k == 8) START = 1'b1;
            if (mode == 2 && k == 10) START = 1'b0;
            @(negedge CLK);
            k++;
        end
        check({tag, ":run_len"}, 32'(k), 32'(RunLen));
        ref_run(gn, TT_NAND2, e_n, f_n);
        ref_run(ga, TT_AND2, e_a, f_a);
        check({tag, ":busy_at_done"}, 32'(busy_n), 32'd0);
        check({tag, ":dut_a_done"}, 32'(dut_a_n), 32'd0);
        check({tag, ":err"}, 32'(err_n), 32'(e_n));
        check({tag, ":fail_vec"}, 32'(fail_n), 32'(f_n));
        check({tag, ":pass"}, 32'(pass_n), 32'(e_n == 0));
        check({tag, ":and_done"}, 32'(done_a), 32'd1);
        check({tag, ":and_err"}, 32'(err_a), 32'(e_a));
        check({tag, ":and_fail_vec"}, 32'(fail_a), 32'(f_a));
        check({tag, ":and_pass"}, 32'(pass_a), 32'(e_a == 0));
        lp_n = 0; lf_n = 0; lp_a = 0; lf_a = 0; dn = 0;
        repeat (256) begin
            @(negedge CLK);
            lp_n += int'(led_pass_n);
            lf_n += int'(led_fail_n);
            lp_a += int'(led_pass_a);
            lf_a += int'(led_fail_a);
            dn   += int'(done_n & ~busy_n);
        end
        check({tag, ":done_hold"}, 32'(dn), 32'd256);
        check({tag, ":led_pass"}, 32'(lp_n), (e_n == 0) ? 32'(DutyOn) : 32'd0);
        check({tag, ":led_fail"}, 32'(lf_n), (e_n != 0) ? 32'(DutyOn) : 32'd0);
        check({tag, ":and_led_pass"}, 32'(lp_a), (e_a == 0) ? 32'(DutyOn) : 32'd0);
        check({tag, ":and_led_fail"}, 32'(lf_a), (e_a != 0) ? 32'(DutyOn) : 32'd0);
        START = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int k;
        RST_N = 1'b0;
        START = 1'b0;
        gut_n = TT_NAND2;
        gut_a = TT_NAND2;
        repeat (3) @(negedge CLK);
        check("rst:busy", 32'(busy_n), 32'd0);
        check("rst:done", 32'(done_n), 32'd0);
        check("rst:pass", 32'(pass_n), 32'd0);
        check("rst:err", 32'(err_n), 32'd0);
        check("rst:fail_vec", 32'(fail_n), 32'd0);
        check("rst:dut_a", 32'(dut_a_n), 32'd0);
        check("rst:leds", 32'({led_pass_n, led_fail_n}), 32'd0);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle:busy", 32'(busy_n), 32'd0);

        run("nand", TT_NAND2, TT_NAND2, 0);
        run("stuck1", 4'b1111, TT_NAND2, 0);
        run("restart", TT_NAND2, TT_NAND2, 0);
        run("held", TT_NAND2, TT_OR2, 1);
        run("repulse", TT_XOR2, TT_AND2, 2);

        // Reset during vector 2 settle must wipe everything at once.
        @(negedge CLK);
        gut_n = TT_AND2;
        START = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!busy_n && k < 20);
        for (int i = 0; i < 14; i++) @(negedge CLK);
        check("midrst:err_before", 32'(err_n), 32'd2);
        RST_N = 1'b0;
        #1;
        check("midrst:busy", 32'(busy_n), 32'd0);
        check("midrst:dut_a", 32'(dut_a_n), 32'd0);
        check("midrst:err", 32'(err_n), 32'd0);
        check("midrst:fail_vec", 32'(fail_n), 32'd0);
        check("midrst:done", 32'(done_n), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        check("midrst:stay_idle", 32'({busy_n, done_n}), 32'd0);

        for (int r = 0; r < 6; r++) begin
            run($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
